audio_sdm_out: RTL

Audio back-end that consumes the 4-bit mixed sample stream from the sound generator and drives a single output pin. It generates the `sample_ena` request strobe at an exact average of `SAMPLE_RATE` from the system clock, captures each returned sample, and applies a click-free mute fade. A first-order sigma-delta modulator converts the result into a 1-bit pulse-density stream for an external RC filter. It sits between the sound generator and the top-level audio pin.

---
 rtl/audio_pkg.sv | 16 +
 rtl/sdm1.sv | 31 +++
 rtl/audio_sdm_out.sv | 130 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio back-end: fade states and
// sample/gain widths.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 4;
  localparam int unsigned GAIN_MAX = 16;
  localparam int unsigned GAIN_W   = 5;

  typedef enum logic [1:0] {
    MUTED,
    FADE_IN,
    PLAY,
    FADE_OUT
  } fade_state_e;

endpackage

// File: rtl/sdm1.sv
// First-order sigma-delta modulator: the accumulator carry forms a
// pulse-density stream whose ones density is din / 2**DIN_W.
module sdm1 #(
  parameter int unsigned DIN_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIN_W-1:0] din,
  output logic             dout
);

  logic [DIN_W-1:0] acc_q, acc_d;
  logic             dout_q, dout_d;

  always_comb begin
    {dout_d, acc_d} = {1'b0, acc_q} + {1'b0, din};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/audio_sdm_out.sv
// Audio back-end: fractional-rate sample strobe, delayed sample capture,
// click-free mute fade and 1-bit sigma-delta output.
module audio_sdm_out
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 25_175_000,
  parameter int unsigned SAMPLE_RATE   = 16384,
  parameter int unsigned CAPTURE_DELAY = 2
) (
  input  logic                clock,
  input  logic                reset,
  output logic                sample_ena,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                mute,
  output logic [SAMPLE_W-1:0] sample_held,
  output logic                audio_out,
  output logic                muted
);

  localparam logic [32:0]       RATE_W  = 33'(SAMPLE_RATE);
  localparam logic [32:0]       CLK_W   = 33'(CLK_HZ);
  localparam logic [GAIN_W-1:0] GAIN_TOP = GAIN_W'(GAIN_MAX);

  logic [31:0]              acc_q, acc_d;
  logic [32:0]              acc_sum;
  logic                     ena_d;
  logic [CAPTURE_DELAY-1:0] cap_q, cap_d;
  logic [SAMPLE_W-1:0]      held_q, held_d;
  fade_state_e              state_q, state_d;
  logic [GAIN_W-1:0]        gain_q, gain_d;
  logic [8:0]               prod;
  logic [SAMPLE_W-1:0]      eff;

  always_comb begin
    acc_sum = {1'b0, acc_q} + RATE_W;
    if (acc_sum >= CLK_W) begin
      acc_d = 32'(acc_sum - CLK_W);
      ena_d = 1'b1;
    end else begin
      acc_d = acc_sum[31:0];
      ena_d = 1'b0;
    end
  end

  // The delay line is fed with the next-state strobe, so tap 0 is the
  // registered strobe itself and the last tap fires CAPTURE_DELAY edges on.
  always_comb begin
    cap_d[0] = ena_d;
    for (int unsigned i = 1; i < CAPTURE_DELAY; i++) begin
      cap_d[i] = cap_q[i-1];
    end
    held_d = cap_q[CAPTURE_DELAY-1] ? sample : held_q;
  end

  assign sample_ena = cap_q[0];

  // Fade endpoints saturate so a reversal taken at 0 or 16 cannot wrap gain.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    if (sample_ena) begin
      case (state_q)
        MUTED: begin
          if (!mute) state_d = FADE_IN;
        end
        FADE_IN: begin
          if (mute) begin
            state_d = FADE_OUT;
          end else if (gain_q >= GAIN_TOP - 5'd1) begin
            gain_d  = GAIN_TOP;
            state_d = PLAY;
          end else begin
            gain_d = gain_q + 5'd1;
          end
        end
        PLAY: begin
          if (mute) state_d = FADE_OUT;
        end
        FADE_OUT: begin
          if (!mute) begin
            state_d = FADE_IN;
          end else if (gain_q <= 5'd1) begin
            gain_d  = '0;
            state_d = MUTED;
          end else begin
            gain_d = gain_q - 5'd1;
          end
        end
        default: begin
          state_d = MUTED;
          gain_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    prod = {5'b0, held_q} * {4'b0, gain_q};
    eff  = SAMPLE_W'(prod >> 4);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      cap_q   <= '0;
      held_q  <= '0;
      state_q <= MUTED;
      gain_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      cap_q   <= cap_d;
      held_q  <= held_d;
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  assign sample_held = held_q;
  assign muted       = (state_q == MUTED);

  sdm1 #(
    .DIN_W(SAMPLE_W)
  ) u_sdm (
    .clock(clock),
    .reset(reset),
    .din  (eff),
    .dout (audio_out)
  );

endmodule
